tx_preamble_frame_assembler: RTL and testbench
==============================================

Name: tx_preamble_frame_assembler

Overview:
- TX frame sequencer sitting directly downstream of the short-training, long-training and data-symbol generators; its output feeds the DAC interface.
- On TX_START it enables each source in turn via its ACK line: short preamble, then long preamble, then data symbols.
- It merges the three streams into one registered 28-bit sample stream.
- When OVERLAP_EN=1 it overlap-adds the half-scaled boundary sample at each segment junction.

Parameters:
- SHORT_LEN, 161: valid samples accepted from the short generator (160 + 1 half-scaled tail).
- LONG_LEN, 289: valid samples accepted from the long generator (32 CP + 2x128 + 1 half-scaled tail).
- OVERLAP_EN, 1: 1 = the tail sample of a segment is added to the head sample of the next segment; 0 = pure concatenation.
- TIMEOUT, 16: maximum number of ACK-high cycles without a source VALID before abort.

Ports:
- SYS_CLK  in  1  system clock, all logic on rising edge.
- PHY_RST_N  in  1  synchronous active-low reset.
- TX_START  in  1  single-cycle frame start request; ignored unless in IDLE.
- SHORT_ACK  out  1  enable to the short-training generator.
- SHORT_TRAINING_SEQ  in  28  short-preamble sample, two's complement.
- SHORT_TRAINING_SEQ_VALID  in  1  short sample valid.
- LONG_ACK  out  1  enable to the long-training generator.
- LONG_TRAINING_SEQ  in  28  long-preamble sample, two's complement.
- LONG_TRAINING_SEQ_VALID  in  1  long sample valid.
- DATA_ACK  out  1  enable to the data-symbol source.
- DATA_SYMBOL  in  28  data sample, two's complement.
- DATA_SYMBOL_VALID  in  1  data sample valid.
- DATA_LAST  in  1  qualifies the final data sample; sampled only with DATA_SYMBOL_VALID.
- TX_SAMPLE  out  28  assembled output sample.
- TX_SAMPLE_VALID  out  1  TX_SAMPLE valid.
- TX_SAMPLE_INDEX  out  12  output sample index within the frame; 0 for the first valid sample.
- TX_BUSY  out  1  high in every state except IDLE.
- TX_DONE  out  1  one-cycle pulse at frame completion.
- TX_ERROR  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (PHY_RST_N=0 at a clock edge) clears all outputs, both counters, the overlap register (ovl) and the state (to IDLE). Reset mid-frame aborts immediately with no DONE and no ERROR pulse.
- States: IDLE, SHORT, LONG, DATA, DONE, ERR.
  - IDLE -> SHORT on TX_START.
  - SHORT -> LONG when accepted count reaches SHORT_LEN.
  - LONG -> DATA when accepted count reaches LONG_LEN.
  - DATA -> DONE on an accepted sample with DATA_LAST=1.
  - DONE -> IDLE after 1 cycle; TX_DONE=1 in DONE.
  - Any active state -> ERR on timeout; ERR -> IDLE after 1 cycle; TX_ERROR=1 in ERR.
- ACK outputs are registered. Exactly one ACK is high, and only in the matching state; it drops on the transition edge.
- Accepted count: samples with the current source's VALID=1 while in that state and count < segment length. Samples arriving after the count is full (the generators' 1-cycle ACK latency leaks extra samples) are discarded. The counter resets on each state entry.
- Output latency: TX_SAMPLE/TX_SAMPLE_VALID appear 1 cycle after the accepted input sample. Outputs are otherwise 0, except TX_SAMPLE_INDEX, which holds its value.
- OVERLAP_EN=1:
  - The last accepted SHORT and LONG samples are stored in ovl and not emitted.
  - The first accepted sample of the following segment is emitted as sat28(ovl + sample), then ovl is cleared.
  - The last DATA sample is emitted unmodified.
- OVERLAP_EN=0: every accepted sample is emitted unmodified.
- sat28: 29-bit signed sum, clamped to 0x7FFFFFF / 0x8000000.
- Frame length: OVERLAP_EN=1 emits 448+N samples (N = data samples); OVERLAP_EN=0 emits 450+N.
- TX_SAMPLE_INDEX: increments per emitted sample, starting at 0 each frame, and wraps at 4096.
- Timeout: a counter increments each cycle the active ACK is high with no VALID, clears on VALID, and triggers on reaching TIMEOUT. ERR drops all ACKs and does not flush ovl.
- A TX_START asserted in any state other than IDLE is ignored.

Test Plan:
- Reset: hold PHY_RST_N=0 for 3 cycles -> all outputs 0, TX_BUSY=0.
- Nominal: OVERLAP_EN=1, TX_START with behavioural generators and N=64 data samples ending in DATA_LAST -> 512 TX_SAMPLE_VALID cycles, last index 511, TX_DONE one pulse. The output at index 160 equals sat28(short tail + long head).
- Overlap saturation: short tail 0x7000000, long head 0x2000000 -> output at index 160 is 0x7FFFFFF. Tails 0x8000001 + 0x8000001 -> 0x8000000.
- Extra-sample leak: long generator delivers 291 valid samples -> only 289 are counted, DATA_ACK rises exactly once, and no extra output is emitted.
- Timeout: hold LONG_TRAINING_SEQ_VALID=0 during LONG -> TX_ERROR pulses 16 cycles after LONG_ACK rises, all ACKs drop, state returns to IDLE.
- Mid-frame reset and ignored start: PHY_RST_N=0 during DATA -> all outputs 0 the next cycle. TX_START during LONG -> ignored, the frame completes normally.

Source files
------------

// File: rtl/tx_preamble_frame_assembler.sv
// Sequences short preamble, long preamble and data symbols into one TX sample stream.
// Latency: TX_SAMPLE follows the accepted source sample by one SYS_CLK cycle.
// Backpressure: none downstream; sources are paced by registered ACK, and an ACK with no VALID for TIMEOUT cycles aborts.
module tx_preamble_frame_assembler #(
   parameter int SHORT_LEN  = 161,
   parameter int LONG_LEN   = 289,
   parameter bit OVERLAP_EN = 1'b1,
   parameter int TIMEOUT    = 16
) (
   input  logic        SYS_CLK,
   input  logic        PHY_RST_N,
   input  logic        TX_START,
   output logic        SHORT_ACK,
   input  logic [27:0] SHORT_TRAINING_SEQ,
   input  logic        SHORT_TRAINING_SEQ_VALID,
   output logic        LONG_ACK,
   input  logic [27:0] LONG_TRAINING_SEQ,
   input  logic        LONG_TRAINING_SEQ_VALID,
   output logic        DATA_ACK,
   input  logic [27:0] DATA_SYMBOL,
   input  logic        DATA_SYMBOL_VALID,
   input  logic        DATA_LAST,
   output logic [27:0] TX_SAMPLE,
   output logic        TX_SAMPLE_VALID,
   output logic [11:0] TX_SAMPLE_INDEX,
   output logic        TX_BUSY,
   output logic        TX_DONE,
   output logic        TX_ERROR
);

   localparam int MAX_LEN = (SHORT_LEN > LONG_LEN) ? SHORT_LEN : LONG_LEN;
   localparam int SEG_W   = $clog2(MAX_LEN + 1);
   localparam int TO_W    = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHORT,
      S_LONG,
      S_DATA,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state;
   logic [SEG_W-1:0]  seg_cnt;    // accepted samples in the current segment
   logic [TO_W-1:0]   to_cnt;     // consecutive ACK-high cycles without VALID
   logic [27:0]       ovl;        // held tail of the previous segment
   logic [11:0]       idx_cnt;    // index the next emitted sample will carry

   logic              cur_vld;
   logic [27:0]       cur_dat;
   logic              seg_room;
   logic              seg_last;
   logic              accept;
   logic              hold_tail;
   logic              add_ovl;
   logic [27:0]       emit_dat;

   // Signed 28-bit add, clamped to the representable range instead of wrapping.
   function automatic logic [27:0] sat28(input logic [27:0] a, input logic [27:0] b);
      logic [28:0] sum;
      sum = {a[27], a} + {b[27], b};
      if (sum[28] != sum[27]) begin
         sat28 = sum[28] ? 28'h8000000 : 28'h7FFFFFF;
      end else begin
         sat28 = sum[27:0];
      end
   endfunction

   // Select the source owned by the current state and decide what to do with its sample.
   always_comb begin
      cur_vld  = 1'b0;
      cur_dat  = '0;
      seg_room = 1'b0;
      seg_last = 1'b0;
      case (state)
         S_SHORT: begin
            cur_vld  = SHORT_TRAINING_SEQ_VALID;
            cur_dat  = SHORT_TRAINING_SEQ;
            seg_room = (seg_cnt < SEG_W'(SHORT_LEN));
            seg_last = (seg_cnt == SEG_W'(SHORT_LEN - 1));
         end
         S_LONG: begin
            cur_vld  = LONG_TRAINING_SEQ_VALID;
            cur_dat  = LONG_TRAINING_SEQ;
            seg_room = (seg_cnt < SEG_W'(LONG_LEN));
            seg_last = (seg_cnt == SEG_W'(LONG_LEN - 1));
         end
         S_DATA: begin
            cur_vld  = DATA_SYMBOL_VALID;
            cur_dat  = DATA_SYMBOL;
            seg_room = 1'b1;
            seg_last = DATA_LAST;
         end
         default: begin
         end
      endcase
      accept    = cur_vld && seg_room;
      // Preamble tails are parked for the junction; the final data sample is always sent as-is.
      hold_tail = OVERLAP_EN && seg_last && (state != S_DATA);
      // Only segments that follow another one receive the parked tail; the short head never does,
      // so a tail left behind by an aborted frame cannot leak into the next frame.
      add_ovl   = OVERLAP_EN && (seg_cnt == '0) && ((state == S_LONG) || (state == S_DATA));
      emit_dat  = add_ovl ? sat28(ovl, cur_dat) : cur_dat;
   end

   // Frame FSM with registered ACKs, status pulses and the output sample register.
   always_ff @(posedge SYS_CLK) begin
      if (!PHY_RST_N) begin
         state           <= S_IDLE;
         SHORT_ACK       <= 1'b0;
         LONG_ACK        <= 1'b0;
         DATA_ACK        <= 1'b0;
         TX_SAMPLE       <= '0;
         TX_SAMPLE_VALID <= 1'b0;
         TX_SAMPLE_INDEX <= '0;
         TX_BUSY         <= 1'b0;
         TX_DONE         <= 1'b0;
         TX_ERROR        <= 1'b0;
         seg_cnt         <= '0;
         to_cnt          <= '0;
         ovl             <= '0;
         idx_cnt         <= '0;
      end else begin
         TX_SAMPLE       <= '0;
         TX_SAMPLE_VALID <= 1'b0;
         TX_DONE         <= 1'b0;
         TX_ERROR        <= 1'b0;

         if (accept) begin
            if (hold_tail) begin
               ovl <= cur_dat;
            end else begin
               TX_SAMPLE       <= emit_dat;
               TX_SAMPLE_VALID <= 1'b1;
               TX_SAMPLE_INDEX <= idx_cnt;
               idx_cnt         <= idx_cnt + 12'd1;
               if (add_ovl) begin
                  ovl <= '0;
               end
            end
         end

         case (state)
            S_IDLE: begin
               if (TX_START) begin
                  state     <= S_SHORT;
                  SHORT_ACK <= 1'b1;
                  TX_BUSY   <= 1'b1;
                  seg_cnt   <= '0;
                  to_cnt    <= '0;
                  idx_cnt   <= '0;
               end
            end
            S_SHORT, S_LONG, S_DATA: begin
               if (accept) begin
                  to_cnt <= '0;
                  if (seg_last) begin
                     seg_cnt   <= '0;
                     SHORT_ACK <= 1'b0;
                     LONG_ACK  <= (state == S_SHORT);
                     DATA_ACK  <= (state == S_LONG);
                     if (state == S_SHORT) begin
                        state <= S_LONG;
                     end else if (state == S_LONG) begin
                        state <= S_DATA;
                     end else begin
                        state   <= S_DONE;
                        TX_DONE <= 1'b1;
                     end
                  end else if ((state != S_DATA) || (seg_cnt == '0)) begin
                     // In DATA the count only needs to remember that the head has gone.
                     seg_cnt <= seg_cnt + SEG_W'(1);
                  end
               end else if (cur_vld) begin
                  to_cnt <= '0;
               end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                  state     <= S_ERR;
                  SHORT_ACK <= 1'b0;
                  LONG_ACK  <= 1'b0;
                  DATA_ACK  <= 1'b0;
                  TX_ERROR  <= 1'b1;
                  to_cnt    <= '0;
                  seg_cnt   <= '0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            default: begin
               // DONE and ERR each last one cycle.
               state   <= S_IDLE;
               TX_BUSY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_preamble_frame_assembler.sv
// Directed bench: frame scenarios from a table plus reset/mid-frame-reset sequences.
// Checks an overlap-add instance and a plain concatenation instance driven by the same generators.
// Generators answer ACK on the following cycle and can leak extra long samples after ACK drops.
`timescale 1ns/1ps
module tb_tx_preamble_frame_assembler;

   localparam int SLEN = 161;
   localparam int LLEN = 289;

   typedef struct {
      logic [27:0] s_tail;
      logic [27:0] l_head;
      logic [27:0] l_tail;
      logic [27:0] d_head;
      int          n_data;
      int          l_leak;
      bit          hold_long;
      bit          start_in_long;
      int          exp_cnt;
      int          exp_cat;
      bit          exp_done;
      logic [27:0] exp_j0;
      logic [27:0] exp_j1;
   } vec_t;

   logic        SYS_CLK = 1'b0;
   logic        PHY_RST_N = 1'b0;
   logic        TX_START = 1'b0;
   logic [27:0] SHORT_TRAINING_SEQ = '0;
   logic        SHORT_TRAINING_SEQ_VALID = 1'b0;
   logic [27:0] LONG_TRAINING_SEQ = '0;
   logic        LONG_TRAINING_SEQ_VALID = 1'b0;
   logic [27:0] DATA_SYMBOL = '0;
   logic        DATA_SYMBOL_VALID = 1'b0;
   logic        DATA_LAST = 1'b0;

   logic        o_short_ack, o_long_ack, o_data_ack, o_vld, o_busy, o_done, o_err;
   logic [27:0] o_smp;
   logic [11:0] o_idx;
   logic        c_short_ack, c_long_ack, c_data_ack, c_vld, c_busy, c_done, c_err;
   logic [27:0] c_smp;
   logic [11:0] c_idx;

   always #5 SYS_CLK = ~SYS_CLK;

   tx_preamble_frame_assembler #(.SHORT_LEN(SLEN), .LONG_LEN(LLEN), .OVERLAP_EN(1'b1), .TIMEOUT(16)) u_ovl (
      .SYS_CLK(SYS_CLK), .PHY_RST_N(PHY_RST_N), .TX_START(TX_START),
      .SHORT_ACK(o_short_ack), .SHORT_TRAINING_SEQ(SHORT_TRAINING_SEQ), .SHORT_TRAINING_SEQ_VALID(SHORT_TRAINING_SEQ_VALID),
      .LONG_ACK(o_long_ack), .LONG_TRAINING_SEQ(LONG_TRAINING_SEQ), .LONG_TRAINING_SEQ_VALID(LONG_TRAINING_SEQ_VALID),
      .DATA_ACK(o_data_ack), .DATA_SYMBOL(DATA_SYMBOL), .DATA_SYMBOL_VALID(DATA_SYMBOL_VALID), .DATA_LAST(DATA_LAST),
      .TX_SAMPLE(o_smp), .TX_SAMPLE_VALID(o_vld), .TX_SAMPLE_INDEX(o_idx),
      .TX_BUSY(o_busy), .TX_DONE(o_done), .TX_ERROR(o_err));

   tx_preamble_frame_assembler #(.SHORT_LEN(SLEN), .LONG_LEN(LLEN), .OVERLAP_EN(1'b0), .TIMEOUT(16)) u_cat (
      .SYS_CLK(SYS_CLK), .PHY_RST_N(PHY_RST_N), .TX_START(TX_START),
      .SHORT_ACK(c_short_ack), .SHORT_TRAINING_SEQ(SHORT_TRAINING_SEQ), .SHORT_TRAINING_SEQ_VALID(SHORT_TRAINING_SEQ_VALID),
      .LONG_ACK(c_long_ack), .LONG_TRAINING_SEQ(LONG_TRAINING_SEQ), .LONG_TRAINING_SEQ_VALID(LONG_TRAINING_SEQ_VALID),
      .DATA_ACK(c_data_ack), .DATA_SYMBOL(DATA_SYMBOL), .DATA_SYMBOL_VALID(DATA_SYMBOL_VALID), .DATA_LAST(DATA_LAST),
      .TX_SAMPLE(c_smp), .TX_SAMPLE_VALID(c_vld), .TX_SAMPLE_INDEX(c_idx),
      .TX_BUSY(c_busy), .TX_DONE(c_done), .TX_ERROR(c_err));

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t cur;
   vec_t tbl[6];
   int   cyc = 0;

   // Stimulus sample patterns (body samples; heads/tails come from the scenario).
   function automatic logic [27:0] short_val(input int i);
      return 28'(i * 3 + 1);
   endfunction
   function automatic logic [27:0] long_val(input int k);
      return 28'(32'h0100000 + k);
   endfunction
   function automatic logic [27:0] data_val(input int k);
      return 28'(32'h0200000 + k);
   endfunction

   function automatic logic [27:0] sat_ref(input logic [27:0] a, input logic [27:0] b);
      longint x, y, s;
      x = $signed(a);
      y = $signed(b);
      s = x + y;
      if (s > 134217727) return 28'h7FFFFFF;
      if (s < -134217728) return 28'h8000000;
      return 28'(s);
   endfunction

   function automatic logic [27:0] exp_ovl(input int i, input vec_t v);
      if (i < 160) return short_val(i);
      if (i == 160) return sat_ref(v.s_tail, v.l_head);
      if (i < 448) return long_val(i - 160);
      if (i == 448) return sat_ref(v.l_tail, v.d_head);
      return data_val(i - 448);
   endfunction

   function automatic logic [27:0] exp_cat(input int i, input vec_t v);
      if (i < 160) return short_val(i);
      if (i == 160) return v.s_tail;
      if (i == 161) return v.l_head;
      if (i < 449) return long_val(i - 161);
      if (i == 449) return v.l_tail;
      if (i == 450) return v.d_head;
      return data_val(i - 450);
   endfunction

   always @(posedge SYS_CLK) cyc <= cyc + 1;

   // Behavioural generators: respond at the negedge after seeing ACK high.
   int s_sent = 0, l_sent = 0, d_sent = 0, leak_left = 0;
   always @(negedge SYS_CLK) begin
      if (!o_busy) begin
         s_sent = 0; l_sent = 0; d_sent = 0; leak_left = cur.l_leak;
      end
      if (o_short_ack && s_sent < SLEN) begin
         SHORT_TRAINING_SEQ_VALID = 1'b1;
         SHORT_TRAINING_SEQ = (s_sent == SLEN - 1) ? cur.s_tail : short_val(s_sent);
         s_sent++;
      end else begin
         SHORT_TRAINING_SEQ_VALID = 1'b0;
         SHORT_TRAINING_SEQ = '0;
      end
      if (o_long_ack && !cur.hold_long && l_sent < LLEN) begin
         LONG_TRAINING_SEQ_VALID = 1'b1;
         LONG_TRAINING_SEQ = (l_sent == 0) ? cur.l_head : (l_sent == LLEN - 1) ? cur.l_tail : long_val(l_sent);
         l_sent++;
      end else if (!o_long_ack && l_sent == LLEN && leak_left > 0) begin
         LONG_TRAINING_SEQ_VALID = 1'b1;
         LONG_TRAINING_SEQ = 28'h5555555;
         leak_left--;
      end else begin
         LONG_TRAINING_SEQ_VALID = 1'b0;
         LONG_TRAINING_SEQ = '0;
      end
      if (o_data_ack && d_sent < cur.n_data) begin
         DATA_SYMBOL_VALID = 1'b1;
         DATA_SYMBOL = (d_sent == 0) ? cur.d_head : data_val(d_sent);
         DATA_LAST = (d_sent == cur.n_data - 1);
         d_sent++;
      end else begin
         DATA_SYMBOL_VALID = 1'b0;
         DATA_SYMBOL = '0;
         DATA_LAST = 1'b0;
      end
   end

   // Output monitor: per-frame counters, cleared when TX_BUSY rises.
   int          o_cnt = 0, c_cnt = 0, o_bad = 0, c_bad = 0;
   int          done_n = 0, err_n = 0, data_rise_n = 0, ack_diff = 0;
   int          long_rise_cyc = 0, err_cyc = 0;
   logic [27:0] o_j0 = '0, o_j1 = '0;
   logic [11:0] o_last = '0;
   logic [2:0]  acks_at_err = '0;
   logic        busy_q = 1'b0, long_q = 1'b0, data_q = 1'b0;
   always @(negedge SYS_CLK) begin
      if (o_busy && !busy_q) begin
         o_cnt = 0; c_cnt = 0; o_bad = 0; c_bad = 0;
         done_n = 0; err_n = 0; data_rise_n = 0; ack_diff = 0;
      end
      if (o_vld) begin
         if (o_idx != 12'(o_cnt) || o_smp != exp_ovl(o_cnt, cur)) o_bad++;
         if (o_cnt == 160) o_j0 = o_smp;
         if (o_cnt == 448) o_j1 = o_smp;
         o_last = o_idx;
         o_cnt++;
      end
      if (c_vld) begin
         if (c_idx != 12'(c_cnt) || c_smp != exp_cat(c_cnt, cur)) c_bad++;
         c_cnt++;
      end
      if (o_done) done_n++;
      if (o_err) begin
         err_n++;
         err_cyc = cyc;
         acks_at_err = {o_short_ack, o_long_ack, o_data_ack};
      end
      if (o_long_ack && !long_q) long_rise_cyc = cyc;
      if (o_data_ack && !data_q) data_rise_n++;
      if ({o_short_ack, o_long_ack, o_data_ack, o_busy, o_done, o_err} !=
          {c_short_ack, c_long_ack, c_data_ack, c_busy, c_done, c_err}) ack_diff++;
      busy_q = o_busy;
      long_q = o_long_ack;
      data_q = o_data_ack;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v, input int r);
      bit poked;
      bit ended;
      cur = v;
      @(negedge SYS_CLK);
      TX_START = 1'b1;
      @(negedge SYS_CLK);
      TX_START = 1'b0;
      poked = 1'b0;
      ended = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge SYS_CLK);
         if (v.start_in_long && o_long_ack && !poked) begin
            TX_START = 1'b1;
            poked = 1'b1;
         end else begin
            TX_START = 1'b0;
         end
         if (!o_busy) begin
            ended = 1'b1;
            break;
         end
      end
      TX_START = 1'b0;
      repeat (2) @(negedge SYS_CLK);
      chk($sformatf("r%0d_frame_end", r), ended, 1);
      chk($sformatf("r%0d_ovl_count", r), o_cnt, v.exp_cnt);
      chk($sformatf("r%0d_cat_count", r), c_cnt, v.exp_cat);
      chk($sformatf("r%0d_ovl_stream_errs", r), o_bad, 0);
      chk($sformatf("r%0d_cat_stream_errs", r), c_bad, 0);
      chk($sformatf("r%0d_done_pulses", r), done_n, v.exp_done);
      chk($sformatf("r%0d_error_pulses", r), err_n, !v.exp_done);
      chk($sformatf("r%0d_data_ack_rises", r), data_rise_n, v.exp_done);
      chk($sformatf("r%0d_ack_agree", r), ack_diff, 0);
      chk($sformatf("r%0d_last_index", r), o_last, v.exp_cnt - 1);
      if (v.exp_cnt > 160) chk($sformatf("r%0d_junction0", r), o_j0, v.exp_j0);
      if (v.exp_cnt > 448) chk($sformatf("r%0d_junction1", r), o_j1, v.exp_j1);
      if (!v.exp_done) begin
         chk($sformatf("r%0d_timeout_delay", r), err_cyc - long_rise_cyc, 16);
         chk($sformatf("r%0d_acks_at_error", r), acks_at_err, 0);
      end
   endtask

   initial begin
      //            s_tail        l_head        l_tail        d_head        N   leak hold sil cnt  cat  done j0            j1
      tbl[0] = '{28'h0000123, 28'h0000456, 28'h0000010, 28'h0000020, 64,   0, 0, 0, 512, 514, 1, 28'h0000579, 28'h0000030};
      tbl[1] = '{28'h7000000, 28'h2000000, 28'h0000000, 28'h0000005, 4,    0, 0, 0, 452, 454, 1, 28'h7FFFFFF, 28'h0000005};
      tbl[2] = '{28'h8000001, 28'h8000001, 28'h8000001, 28'h8000001, 3,    0, 0, 0, 451, 453, 1, 28'h8000000, 28'h8000000};
      tbl[3] = '{28'h0000001, 28'h0000002, 28'hFFFFFFF, 28'h0000001, 10,   2, 0, 0, 458, 460, 1, 28'h0000003, 28'h0000000};
      tbl[4] = '{28'h0ABCDEF, 28'h0000000, 28'h0000000, 28'h0000000, 5,    0, 1, 0, 160, 161, 0, 28'h0000000, 28'h0000000};
      tbl[5] = '{28'h0000100, 28'h0000200, 28'h0000003, 28'h0000007, 1,    0, 0, 1, 449, 451, 1, 28'h0000300, 28'h000000A};
      cur = tbl[0];

      // Reset held for three cycles.
      PHY_RST_N = 1'b0;
      repeat (3) @(posedge SYS_CLK);
      @(negedge SYS_CLK);
      chk("reset_ovl_outputs", {o_short_ack, o_long_ack, o_data_ack, o_smp, o_vld, o_idx, o_busy, o_done, o_err}, 0);
      chk("reset_cat_outputs", {c_short_ack, c_long_ack, c_data_ack, c_smp, c_vld, c_idx, c_busy, c_done, c_err}, 0);
      PHY_RST_N = 1'b1;
      repeat (2) @(negedge SYS_CLK);

      for (int r = 0; r < 6; r++) run_frame(tbl[r], r);

      // Reset while data symbols are flowing.
      begin
         vec_t v;
         bit   seen;
         v = tbl[0];
         v.n_data = 1000;
         cur = v;
         @(negedge SYS_CLK);
         TX_START = 1'b1;
         @(negedge SYS_CLK);
         TX_START = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 1000; c++) begin
            @(negedge SYS_CLK);
            if (o_data_ack) begin
               seen = 1'b1;
               break;
            end
         end
         chk("midreset_reached_data", seen, 1);
         repeat (5) @(negedge SYS_CLK);
         PHY_RST_N = 1'b0;
         @(negedge SYS_CLK);
         chk("midreset_ovl_outputs", {o_short_ack, o_long_ack, o_data_ack, o_smp, o_vld, o_idx, o_busy, o_done, o_err}, 0);
         chk("midreset_cat_outputs", {c_short_ack, c_long_ack, c_data_ack, c_smp, c_vld, c_idx, c_busy, c_done, c_err}, 0);
         repeat (2) @(negedge SYS_CLK);
         chk("midreset_no_done_err", done_n + err_n, 0);
         PHY_RST_N = 1'b1;
         @(negedge SYS_CLK);
      end

      run_frame(tbl[0], 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
